ctrl_seq: RTL and testbench

- Parametrised, multi-cycle control sequencer for the accumulator CPU. It is the successor to the fixed 8-bit control unit.
- Drives load strobes, datapath mux selects, ALU op and memory write for the PC/MAR/MDR/IR/ACC datapath.
- Adds the following:
  - a decoded instruction set;
  - a memory wait-state handshake;
  - conditional branching;
  - a halt/resume mechanism;
  - illegal-opcode reporting.

---
 rtl/ctrl_seq_pkg.sv | 49 ++++
 rtl/ctrl_seq_decode.sv | 48 ++++
 rtl/ctrl_seq.sv | 183 ++++++++++++++++++
 tb/tb_ctrl_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the accumulator-CPU control sequencer:
// state encoding, opcode values, ALU operation codes and the decoded
// instruction class used between the decoder and the sequencer.
package ctrl_seq_pkg;

  // Sequencer states; the encoding is exported on o_state for debug.
  typedef enum logic [3:0] {
    FETCH_A = 4'd0,
    FETCH_M = 4'd1,
    FETCH_I = 4'd2,
    DECODE  = 4'd3,
    EXEC_A  = 4'd4,
    EXEC_M  = 4'd5,
    EXEC_W  = 4'd6,
    INC     = 4'd7,
    JUMP    = 4'd8,
    HALT    = 4'd9
  } state_e;

  // Opcode values (upper OPC_W bits of IR).
  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LDA = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_STA = 4;
  localparam int unsigned OP_JMP = 5;
  localparam int unsigned OP_JZ  = 6;
  localparam int unsigned OP_HLT = 7;

  // ALU control values.
  localparam int unsigned ALU_PASS = 0;
  localparam int unsigned ALU_ADD  = 1;
  localparam int unsigned ALU_SUB  = 2;

  // Instruction class: what the sequencer needs to know to route the
  // instruction after DECODE. ADD and SUB share a class and differ only in
  // the ALU op carried alongside.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_LOAD,
    CLS_ALU,
    CLS_STORE,
    CLS_JMP,
    CLS_JZ,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational opcode decoder: maps the opcode field onto an instruction
// class, the ALU operation for EXEC_W and an illegal-opcode flag. Any value
// beyond the eight defined opcodes (only reachable when OPC_W > 3) is illegal.
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int OPC_W    = 3,
  parameter int ALU_OP_W = 2
) (
  input  logic [OPC_W-1:0]    i_opc,
  output op_class_e           o_cls,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_illegal
);

  logic [31:0] w_opc_val;

  assign w_opc_val = 32'(i_opc);

  // Opcode lookup; unlisted values fall through to the illegal defaults.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    o_cls     = CLS_ILLEGAL;
    o_alu_op  = ALU_OP_W'(ALU_PASS);
    o_illegal = 1'b1;
    case (w_opc_val)
      OP_NOP: begin o_cls = CLS_NOP;   o_illegal = 1'b0; end
      OP_LDA: begin o_cls = CLS_LOAD;  o_illegal = 1'b0; end
      OP_ADD: begin
        o_cls     = CLS_ALU;
        o_alu_op  = ALU_OP_W'(ALU_ADD);
        o_illegal = 1'b0;
      end
      OP_SUB: begin
        o_cls     = CLS_ALU;
        o_alu_op  = ALU_OP_W'(ALU_SUB);
        o_illegal = 1'b0;
      end
      OP_STA: begin o_cls = CLS_STORE; o_illegal = 1'b0; end
      OP_JMP: begin o_cls = CLS_JMP;   o_illegal = 1'b0; end
      OP_JZ:  begin o_cls = CLS_JZ;    o_illegal = 1'b0; end
      OP_HLT: begin o_cls = CLS_HALT;  o_illegal = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the PC/MAR/MDR/IR/ACC accumulator
// datapath. Moore-style outputs decoded from the registered state; the only
// input-qualified strobes are the memory-completion ones (ld_mdr, mem_we),
// the DECODE-cycle illegal pulse, and the HALT exit on i_run.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int OPC_W    = 3,
  parameter int ALU_OP_W = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BITS-1:0]     i_opcode,
  input  logic                i_acc_zero,
  input  logic                i_mem_ready,
  input  logic                i_run,
  output logic                o_ld_mdr,
  output logic                o_ld_mar,
  output logic                o_ld_ir,
  output logic                o_ld_pc,
  output logic                o_ld_acc,
  output logic                o_mem_we,
  output logic                o_mux_ir_p1,
  output logic                o_mux_mdr_alur,
  output logic                o_mux_pc_ird,
  output logic [ALU_OP_W-1:0] o_alu_ctrl,
  output logic                o_halted,
  output logic                o_illegal,
  output logic [3:0]          o_state
);

  state_e              r_state;
  op_class_e           r_cls;
  logic [ALU_OP_W-1:0] r_alu_op;

  state_e              w_next;
  op_class_e           w_cls;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_dec_illegal;
  logic [OPC_W-1:0]    w_opc;
  logic                w_unused_operand;

  logic w_ld_mdr, w_ld_mar, w_ld_ir, w_ld_pc, w_ld_acc, w_mem_we;
  logic w_mux_ir_p1, w_mux_mdr_alur, w_mux_pc_ird;
  logic w_halted, w_illegal;
  logic [ALU_OP_W-1:0] w_alu_ctrl;

  assign w_opc = i_opcode[BITS-1 -: OPC_W];
  // Operand bits feed the PC/MAR muxes in the datapath, not the sequencer.
  assign w_unused_operand = ^i_opcode[BITS-OPC_W-1:0];

  ctrl_seq_decode #(
    .OPC_W    (OPC_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .i_opc     (w_opc),
    .o_cls     (w_cls),
    .o_alu_op  (w_alu_op),
    .o_illegal (w_dec_illegal)
  );

  // State register plus the opcode class/ALU op captured in DECODE, so later
  // states ignore any change on i_opcode.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      r_state  <= FETCH_A;
      // NOTE: the captured class is reset too, so EXEC states can never act
      // on stale contents even if reached through an unexpected path.
      r_cls    <= CLS_NOP;
      r_alu_op <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_cls    <= w_cls;
        r_alu_op <= w_alu_op;
      end
    end
  end

  // Next-state and output decode; everything is held at 0 while in reset.
  always_comb begin
    w_next         = r_state;
    w_ld_mdr       = 1'b0;
    w_ld_mar       = 1'b0;
    w_ld_ir        = 1'b0;
    w_ld_pc        = 1'b0;
    w_ld_acc       = 1'b0;
    w_mem_we       = 1'b0;
    w_mux_ir_p1    = 1'b0;
    w_mux_mdr_alur = 1'b0;
    w_mux_pc_ird   = 1'b0;
    w_alu_ctrl     = ALU_OP_W'(ALU_PASS);
    w_halted       = 1'b0;
    w_illegal      = 1'b0;
    if (!i_rst) begin
      case (r_state)
        FETCH_A: begin
          w_ld_mar = 1'b1;
          w_next   = FETCH_M;
        end
        FETCH_M: begin
          if (i_mem_ready) begin
            w_ld_mdr = 1'b1;
            w_next   = FETCH_I;
          end
        end
        FETCH_I: begin
          w_ld_ir = 1'b1;
          w_next  = DECODE;
        end
        DECODE: begin
          case (w_cls)
            CLS_NOP:     w_next = INC;
            CLS_LOAD,
            CLS_ALU,
            CLS_STORE:   w_next = EXEC_A;
            CLS_JMP:     w_next = JUMP;
            CLS_JZ:      w_next = i_acc_zero ? JUMP : INC;
            CLS_HALT:    w_next = HALT;
            default: begin
              w_illegal = w_dec_illegal;
              w_next    = INC;
            end
          endcase
        end
        EXEC_A: begin
          w_mux_pc_ird = 1'b1;
          w_ld_mar     = 1'b1;
          w_next       = EXEC_M;
        end
        EXEC_M: begin
          if (i_mem_ready) begin
            if (r_cls == CLS_STORE) begin
              w_mem_we = 1'b1;
              w_next   = INC;
            end else begin
              w_ld_mdr = 1'b1;
              w_next   = EXEC_W;
            end
          end
        end
        EXEC_W: begin
          w_ld_acc       = 1'b1;
          w_mux_mdr_alur = (r_cls == CLS_ALU);
          w_alu_ctrl     = r_alu_op;
          w_next         = INC;
        end
        INC: begin
          w_ld_pc = 1'b1;
          w_next  = FETCH_A;
        end
        JUMP: begin
          w_mux_ir_p1 = 1'b1;
          w_ld_pc     = 1'b1;
          w_next      = FETCH_A;
        end
        HALT: begin
          w_halted = 1'b1;
          if (i_run) w_next = INC;
        end
        default: w_next = FETCH_A;
      endcase
    end
  end

  assign o_ld_mdr       = w_ld_mdr;
  assign o_ld_mar       = w_ld_mar;
  assign o_ld_ir        = w_ld_ir;
  assign o_ld_pc        = w_ld_pc;
  assign o_ld_acc       = w_ld_acc;
  assign o_mem_we       = w_mem_we;
  assign o_mux_ir_p1    = w_mux_ir_p1;
  assign o_mux_mdr_alur = w_mux_mdr_alur;
  assign o_mux_pc_ird   = w_mux_pc_ird;
  assign o_alu_ctrl     = w_alu_ctrl;
  assign o_halted       = w_halted;
  assign o_illegal      = w_illegal;
  assign o_state        = r_state;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: a cycle-by-cycle model of each instruction
// pushes {stimulus, expected outputs} items; each test drains the queue,
// driving one cycle per item and comparing at the falling edge.
// Instance A uses default parameters, instance B uses BITS=12, OPC_W=4.
module tb_ctrl_seq;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_acc;
    logic       mem_we;
    logic       mux_ir_p1;
    logic       mux_mdr_alur;
    logic       mux_pc_ird;
    logic [1:0] alu;
    logic       halted;
    logic       illegal;
    logic [3:0] state;
  } outv_t;

  typedef struct {
    bit          dut_b;
    logic        rst;
    logic        ready;
    logic        run;
    logic        zero;
    logic [11:0] ir;
    outv_t       exp;
    string       tag;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       a_rst = 1'b1, a_zero = 1'b0, a_ready = 1'b1, a_run = 1'b0;
  logic [7:0] a_opcode = '0;
  logic       a_ld_mdr, a_ld_mar, a_ld_ir, a_ld_pc, a_ld_acc, a_mem_we;
  logic       a_mux_ir_p1, a_mux_mdr_alur, a_mux_pc_ird, a_halted, a_illegal;
  logic [1:0] a_alu;
  logic [3:0] a_state;

  // Instance B signals
  logic        b_rst = 1'b1, b_zero = 1'b0, b_ready = 1'b1, b_run = 1'b0;
  logic [11:0] b_opcode = '0;
  logic        b_ld_mdr, b_ld_mar, b_ld_ir, b_ld_pc, b_ld_acc, b_mem_we;
  logic        b_mux_ir_p1, b_mux_mdr_alur, b_mux_pc_ird, b_halted, b_illegal;
  logic [1:0]  b_alu;
  logic [3:0]  b_state;

  ctrl_seq u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_opcode(a_opcode), .i_acc_zero(a_zero),
    .i_mem_ready(a_ready), .i_run(a_run),
    .o_ld_mdr(a_ld_mdr), .o_ld_mar(a_ld_mar), .o_ld_ir(a_ld_ir),
    .o_ld_pc(a_ld_pc), .o_ld_acc(a_ld_acc), .o_mem_we(a_mem_we),
    .o_mux_ir_p1(a_mux_ir_p1), .o_mux_mdr_alur(a_mux_mdr_alur),
    .o_mux_pc_ird(a_mux_pc_ird), .o_alu_ctrl(a_alu), .o_halted(a_halted),
    .o_illegal(a_illegal), .o_state(a_state)
  );

  ctrl_seq #(.BITS(12), .OPC_W(4), .ALU_OP_W(2)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_opcode(b_opcode), .i_acc_zero(b_zero),
    .i_mem_ready(b_ready), .i_run(b_run),
    .o_ld_mdr(b_ld_mdr), .o_ld_mar(b_ld_mar), .o_ld_ir(b_ld_ir),
    .o_ld_pc(b_ld_pc), .o_ld_acc(b_ld_acc), .o_mem_we(b_mem_we),
    .o_mux_ir_p1(b_mux_ir_p1), .o_mux_mdr_alur(b_mux_mdr_alur),
    .o_mux_pc_ird(b_mux_pc_ird), .o_alu_ctrl(b_alu), .o_halted(b_halted),
    .o_illegal(b_illegal), .o_state(b_state)
  );

  function automatic outv_t cap_a();
    outv_t v;
    v = '{a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_pc, a_ld_acc, a_mem_we,
          a_mux_ir_p1, a_mux_mdr_alur, a_mux_pc_ird, a_alu, a_halted,
          a_illegal, a_state};
    return v;
  endfunction

  function automatic outv_t cap_b();
    outv_t v;
    v = '{b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_pc, b_ld_acc, b_mem_we,
          b_mux_ir_p1, b_mux_mdr_alur, b_mux_pc_ird, b_alu, b_halted,
          b_illegal, b_state};
    return v;
  endfunction

  function automatic outv_t st_only(input logic [3:0] s);
    outv_t v;
    v = '0;
    v.state = s;
    return v;
  endfunction

  task automatic push(input bit dut_b, input logic rst, input logic ready,
                      input logic run, input logic zero, input logic [11:0] ir,
                      input outv_t exp, input string tag);
    item_t it;
    it.dut_b = dut_b; it.rst = rst; it.ready = ready; it.run = run;
    it.zero = zero; it.ir = ir; it.exp = exp; it.tag = tag;
    sb.push_back(it);
  endtask

  // Expected per-cycle behaviour of one instruction from FETCH_A to its
  // final INC/JUMP. late_ir is driven on i_opcode after DECODE.
  task automatic push_instr(input bit dut_b, input logic [11:0] ir,
                            input int fwait, input int ewait, input logic zero,
                            input int hcycles, input logic [11:0] late_ir);
    int    opc;
    bit    jump;
    outv_t v;
    opc  = dut_b ? int'(ir[11:8]) : int'(ir[7:5]);
    jump = 1'b0;
    v = st_only(4'd0); v.ld_mar = 1'b1;
    push(dut_b, 1'b0, 1'b1, 1'b0, zero, ir, v, "fetch_a");
    for (int i = 0; i < fwait; i++)
      push(dut_b, 1'b0, 1'b0, 1'b0, zero, ir, st_only(4'd1), "fetch_wait");
    v = st_only(4'd1); v.ld_mdr = 1'b1;
    push(dut_b, 1'b0, 1'b1, 1'b0, zero, ir, v, "fetch_m");
    v = st_only(4'd2); v.ld_ir = 1'b1;
    push(dut_b, 1'b0, 1'b1, 1'b0, zero, ir, v, "fetch_i");
    v = st_only(4'd3); v.illegal = (opc > 7);
    push(dut_b, 1'b0, 1'b1, 1'b0, zero, ir, v, "decode");
    case (opc)
      1, 2, 3, 4: begin
        v = st_only(4'd4); v.mux_pc_ird = 1'b1; v.ld_mar = 1'b1;
        push(dut_b, 1'b0, 1'b1, 1'b0, zero, late_ir, v, "exec_a");
        for (int i = 0; i < ewait; i++)
          push(dut_b, 1'b0, 1'b0, 1'b0, zero, late_ir, st_only(4'd5), "exec_wait");
        v = st_only(4'd5);
        if (opc == 4) v.mem_we = 1'b1;
        else          v.ld_mdr = 1'b1;
        push(dut_b, 1'b0, 1'b1, 1'b0, zero, late_ir, v, "exec_m");
        if (opc != 4) begin
          v = st_only(4'd6); v.ld_acc = 1'b1;
          v.alu = (opc == 1) ? 2'd0 : (opc == 2) ? 2'd1 : 2'd2;
          v.mux_mdr_alur = (opc != 1);
          push(dut_b, 1'b0, 1'b1, 1'b0, zero, late_ir, v, "exec_w");
        end
      end
      5: jump = 1'b1;
      6: jump = zero;
      7: begin
        v = st_only(4'd9); v.halted = 1'b1;
        for (int i = 0; i < hcycles; i++)
          push(dut_b, 1'b0, 1'b1, 1'b0, zero, late_ir, v, "halt_hold");
        push(dut_b, 1'b0, 1'b1, 1'b1, zero, late_ir, v, "halt_run");
      end
      default: ;
    endcase
    if (jump) begin
      v = st_only(4'd8); v.mux_ir_p1 = 1'b1; v.ld_pc = 1'b1;
      push(dut_b, 1'b0, 1'b1, 1'b0, zero, late_ir, v, "jump");
    end else begin
      v = st_only(4'd7); v.ld_pc = 1'b1;
      push(dut_b, 1'b0, 1'b1, 1'b0, zero, late_ir, v, "inc");
    end
  endtask

  // Drive one cycle of stimulus (the idle instance is held in reset) and
  // return the outputs observed at the falling edge.
  task automatic drive(input item_t it, output outv_t obs);
    if (it.dut_b) begin
      b_rst = it.rst; b_ready = it.ready; b_run = it.run; b_zero = it.zero;
      b_opcode = it.ir; a_rst = 1'b1;
    end else begin
      a_rst = it.rst; a_ready = it.ready; a_run = it.run; a_zero = it.zero;
      a_opcode = it.ir[7:0]; b_rst = 1'b1;
    end
    @(negedge clk);
    obs = it.dut_b ? cap_b() : cap_a();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    outv_t z;
    z = st_only(4'd0);
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, z, "reset_0");
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, z, "reset_1");
    push_instr(1'b0, 12'h000, 0, 0, 1'b0, 0, 12'h000);
    while (sb.size() > 0) begin
      item_t it;
      outv_t obs;
      it = sb.pop_front();
      drive(it, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL reset/%s: got %h, expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic test_lda_add();
    push_instr(1'b0, 12'h025, 0, 0, 1'b0, 0, 12'h025);
    // ADD, with i_opcode switched to SUB once DECODE has passed.
    push_instr(1'b0, 12'h046, 0, 0, 1'b0, 0, 12'h066);
    push_instr(1'b0, 12'h071, 0, 1, 1'b0, 0, 12'h071);
    while (sb.size() > 0) begin
      item_t it;
      outv_t obs;
      it = sb.pop_front();
      drive(it, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL lda_add/%s: got %h, expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic test_sta_wait();
    int n_we;
    int n_cyc;
    n_we  = 0;
    n_cyc = 0;
    push_instr(1'b0, 12'h083, 0, 3, 1'b0, 0, 12'h083);
    while (sb.size() > 0) begin
      item_t it;
      outv_t obs;
      it = sb.pop_front();
      drive(it, obs);
      n_cyc++;
      if (obs.mem_we === 1'b1) n_we++;
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL sta_wait/%s: got %h, expected %h", it.tag, obs, it.exp);
      end
    end
    n_checks++;
    if (n_we !== 1) begin
      n_fail++;
      $display("FAIL sta_we_count: got %0d pulses, expected 1", n_we);
    end
    n_checks++;
    if (n_cyc !== 10) begin
      n_fail++;
      $display("FAIL sta_latency: got %0d cycles, expected 10", n_cyc);
    end
  endtask

  task automatic test_branch();
    push_instr(1'b0, 12'h0C9, 0, 0, 1'b1, 0, 12'h0C9);
    push_instr(1'b0, 12'h0C9, 0, 0, 1'b0, 0, 12'h0C9);
    push_instr(1'b0, 12'h0A3, 2, 0, 1'b0, 0, 12'h0A3);
    while (sb.size() > 0) begin
      item_t it;
      outv_t obs;
      it = sb.pop_front();
      drive(it, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL branch/%s: got %h, expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic test_halt();
    push_instr(1'b0, 12'h0E0, 0, 0, 1'b0, 20, 12'h0E0);
    push_instr(1'b0, 12'h000, 0, 0, 1'b0, 0, 12'h000);
    while (sb.size() > 0) begin
      item_t it;
      outv_t obs;
      it = sb.pop_front();
      drive(it, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL halt/%s: got %h, expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic test_illegal_reset_mid();
    outv_t v;
    int    n_ill;
    n_ill = 0;
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, st_only(4'd0), "b_reset_0");
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, st_only(4'd0), "b_reset_1");
    push_instr(1'b1, 12'hF00, 0, 0, 1'b0, 0, 12'hF00);
    push_instr(1'b1, 12'h800, 0, 0, 1'b0, 0, 12'h800);
    push_instr(1'b1, 12'h3AB, 0, 0, 1'b0, 0, 12'h3AB);
    // STA interrupted by reset while waiting in EXEC_M.
    v = st_only(4'd0); v.ld_mar = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h4AB, v, "mid_fetch_a");
    v = st_only(4'd1); v.ld_mdr = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h4AB, v, "mid_fetch_m");
    v = st_only(4'd2); v.ld_ir = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h4AB, v, "mid_fetch_i");
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h4AB, st_only(4'd3), "mid_decode");
    v = st_only(4'd4); v.mux_pc_ird = 1'b1; v.ld_mar = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h4AB, v, "mid_exec_a");
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h4AB, st_only(4'd5), "mid_exec_wait");
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h4AB, st_only(4'd5), "mid_rst_in_exec_m");
    push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h4AB, st_only(4'd0), "mid_rst_hold");
    push_instr(1'b1, 12'h000, 0, 0, 1'b0, 0, 12'h000);
    while (sb.size() > 0) begin
      item_t it;
      outv_t obs;
      it = sb.pop_front();
      drive(it, obs);
      if (obs.illegal === 1'b1) n_ill++;
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL illegal_rst/%s: got %h, expected %h", it.tag, obs, it.exp);
      end
    end
    n_checks++;
    if (n_ill !== 2) begin
      n_fail++;
      $display("FAIL illegal_pulse_count: got %0d, expected 2", n_ill);
    end
  endtask

  initial begin
    // One unchecked reset edge brings both instances to a known state.
    @(posedge clk);
    #1;
    test_reset();
    test_lda_add();
    test_sta_wait();
    test_branch();
    test_halt();
    test_illegal_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
